// File: rtl/io_port_arbiter.sv
// io_port_arbiter: shares one output register and one synchronised input port between two
// four-phase req/ack requesters (0 = monitor, 1 = CPU). Simultaneous requests are granted
// round-robin. Every output comes straight from a flop.
module io_port_arbiter #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OPORT_INIT  = 8'h00
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] wd0,
    output logic [WIDTH-1:0] rd0,
    output logic             ack0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] wd1,
    output logic [WIDTH-1:0] rd1,
    output logic             ack1,
    input  logic [WIDTH-1:0] iport,
    output logic [WIDTH-1:0] oport,
    output logic             oport_stb
);

    typedef enum logic [2:0] {
        StIdle,
        StServe0,
        StServe1,
        StWait0,
        StWait1
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;   // requester granted most recently
    logic             we_q, we_d;       // write enable latched at grant
    logic [WIDTH-1:0] wd_q, wd_d;       // write data latched at grant
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [WIDTH-1:0] rd0_q, rd0_d;
    logic [WIDTH-1:0] rd1_q, rd1_d;
    logic [WIDTH-1:0] oport_q, oport_d;
    logic             stb_q, stb_d;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  iport_s;

    assign iport_s = sync_q[SYNC_STAGES-1];

    // Input synchroniser: iport shifts in at stage 0, reads use the last stage only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iport};
        end
    end

    // Arbitration FSM next-state and output-register next values.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        we_d    = we_q;
        wd_d    = wd_q;
        ack0_d  = ack0_q;
        ack1_d  = ack1_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        oport_d = oport_q;
        stb_d   = 1'b0;
        case (state_q)
            StIdle: begin
                // On a tie requester 0 wins only if requester 1 went last.
                if (req0 && (!req1 || last_q)) begin
                    state_d = StServe0;
                    last_d  = 1'b0;
                    we_d    = we0;
                    wd_d    = wd0;
                end else if (req1) begin
                    state_d = StServe1;
                    last_d  = 1'b1;
                    we_d    = we1;
                    wd_d    = wd1;
                end
            end
            StServe0: begin
                if (we_q) begin
                    oport_d = wd_q;
                    stb_d   = 1'b1;
                end
                rd0_d   = iport_s;
                ack0_d  = 1'b1;
                state_d = StWait0;
            end
            StServe1: begin
                if (we_q) begin
                    oport_d = wd_q;
                    stb_d   = 1'b1;
                end
                rd1_d   = iport_s;
                ack1_d  = 1'b1;
                state_d = StWait1;
            end
            StWait0: begin
                if (!req0) begin
                    ack0_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StWait1: begin
                if (!req1) begin
                    ack1_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset discards any transaction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            wd_q    <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            oport_q <= OPORT_INIT;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            oport_q <= oport_d;
            stb_q   <= stb_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rd0       = rd0_q;
    assign rd1       = rd1_q;
    assign oport     = oport_q;
    assign oport_stb = stb_q;

    // Only one requester may own the port at a time.
    ack_exclusive: assert property (@(posedge clock) disable iff (!reset_n) !(ack0_q && ack1_q));

endmodule
